// File: rtl/systolic_feeder_pkg.sv
// Shared types and sizing helpers for the systolic array feeder.
//   feeder_state_e : top-level sequencing states
//   idx_w / cnt_w  : counter widths that never collapse to zero bits
//   lane_lo        : low bit of lane `lane` in a flat packed vector
package systolic_feeder_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, SHIFT_W, LATCH, STREAM, FLUSH} feeder_state_e;

  // Width able to index 0..n-1; a single-entry range still gets one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width able to hold 0..max_count inclusive.
  function automatic int cnt_w(input int max_count);
    return idx_w(max_count + 1);
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth delay line of {valid, data} used to skew one activation row.
//   clk, res_n        : clock, async active-low reset
//   in_valid, in_data : element offered this cycle
//   out_valid, out_data : element Depth cycles later
// Data is only captured when valid, so invalid slots repeat the last
// valid element instead of leaking whatever sat on the input bus.
module skew_delay_line #(
  parameter int Depth = 1,
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  output logic [Width-1:0] out_data
);

  logic [Depth-1:0]            vld_pipe;
  logic [Depth-1:0][Width-1:0] dat_pipe;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      if (in_valid) dat_pipe[0] <= in_data;
      for (int i = 1; i < Depth; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[Depth-1];
  assign out_data  = dat_pipe[Depth-1];

endmodule

// File: rtl/systolic_array_feeder.sv
// Sequencer feeding the top and left edges of a Rows x Cols systolic grid.
//   start/num_vectors        : kick off one job (sampled in IDLE)
//   w_valid/w_ready/w_data   : weight tile, one row per beat (beat i = PE row i)
//   a_valid/a_ready/a_data   : activation vectors, element r -> PE row r
//   pe_b, pe_en_l_b          : weight column bus and weight-latch strobe
//   pe_a, pe_in_valid        : row-skewed activations with per-row valid
//   busy, done               : job in flight / one-cycle completion pulse
// Flow: load tile -> shift rows out last-first -> latch -> stream -> flush.
module systolic_array_feeder import systolic_feeder_pkg::*; #(
  parameter  int Rows        = 4,
  parameter  int Cols        = 4,
  parameter  int BitSize     = 8,
  parameter  int M_W_BitSize = 8,
  parameter  int MaxVectors  = 256,
  localparam int CntW        = cnt_w(MaxVectors)
) (
  input  logic                        clk,
  input  logic                        res_n,
  input  logic                        start,
  input  logic [CntW-1:0]             num_vectors,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [Cols*M_W_BitSize-1:0] w_data,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [Rows*BitSize-1:0]     a_data,
  output logic [Cols*M_W_BitSize-1:0] pe_b,
  output logic                        pe_en_l_b,
  output logic [Rows*BitSize-1:0]     pe_a,
  output logic [Rows-1:0]             pe_in_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int BeatW    = idx_w(Rows);
  localparam int FlushW   = idx_w(Rows + Cols);
  localparam int FlushLen = Rows + Cols - 1;  // skew drain + partial-sum drain
  localparam int WW       = Cols * M_W_BitSize;

  feeder_state_e             state;
  logic [BeatW-1:0]          beat_cnt;   // load index, then shift index counting down
  logic [CntW-1:0]           vec_cnt;
  logic [CntW-1:0]           nv;
  logic [FlushW-1:0]         flush_cnt;
  logic [Rows-1:0][WW-1:0]   wbuf;
  logic                      a_acc;

  assign a_acc = a_valid && a_ready;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      vec_cnt   <= '0;
      nv        <= '0;
      flush_cnt <= '0;
      wbuf      <= '0;
      w_ready   <= 1'b0;
      a_ready   <= 1'b0;
      pe_b      <= '0;
      pe_en_l_b <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pe_en_l_b <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          nv       <= num_vectors;
          vec_cnt  <= '0;
          beat_cnt <= '0;
          w_ready  <= 1'b1;
          busy     <= 1'b1;
          state    <= LOAD_W;
        end
        LOAD_W: if (w_valid) begin
          wbuf[beat_cnt] <= w_data;
          if (32'(beat_cnt) == Rows - 1) begin
            // Last beat goes straight onto the bus: the deepest row leads.
            w_ready <= 1'b0;
            pe_b    <= w_data;
            state   <= SHIFT_W;
          end else begin
            beat_cnt <= beat_cnt + BeatW'(1);
          end
        end
        SHIFT_W: begin
          if (beat_cnt == '0) begin
            pe_b      <= '0;
            pe_en_l_b <= 1'b1;
            state     <= LATCH;
          end else begin
            pe_b     <= wbuf[beat_cnt - BeatW'(1)];
            beat_cnt <= beat_cnt - BeatW'(1);
          end
        end
        LATCH: begin
          flush_cnt <= '0;
          if (nv == '0) begin
            done  <= (FlushLen == 1);
            state <= FLUSH;
          end else begin
            a_ready <= 1'b1;
            state   <= STREAM;
          end
        end
        STREAM: if (a_valid) begin
          vec_cnt <= vec_cnt + CntW'(1);
          if (vec_cnt + CntW'(1) == nv) begin
            a_ready   <= 1'b0;
            flush_cnt <= '0;
            done      <= (FlushLen == 1);
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (32'(flush_cnt) == FlushLen - 1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + FlushW'(1);
            // Registered pulse: raise it entering the final flush cycle.
            done      <= (32'(flush_cnt) == FlushLen - 2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row r sees element k r cycles after row 0, forming the diagonal wavefront.
  for (genvar r = 0; r < Rows; r++) begin : g_row
    skew_delay_line #(
      .Depth (r + 1),
      .Width (BitSize)
    ) u_skew (
      .clk       (clk),
      .res_n     (res_n),
      .in_valid  (a_acc),
      .in_data   (a_data[lane_lo(r, BitSize) +: BitSize]),
      .out_valid (pe_in_valid[r]),
      .out_data  (pe_a[lane_lo(r, BitSize) +: BitSize])
    );
  end

endmodule
